// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage in front of decode. Holds the PC, issues word requests to
// instruction memory over a req/ack handshake, registers the returned word and
// presents it to decode together with its PC, PC+4 and the pre-sliced
// op/funct3/funct7 fields. A redirect (PCSrc/PCTarget) squashes any fetch in
// flight so that no stale instruction ever reaches decode.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   imem_req/addr     request and word address towards instruction memory
//   imem_ack/rdata    memory response, rdata valid while ack=1
//   instr_valid       instr/op/funct*/instr_pc* hold a live instruction
//   instr_ready       decode consumes the instruction this cycle
//   instr, op, funct3, funct7   registered instruction and its field slices
//   instr_pc, instr_pc_plus4    PC of instr and PC+4 (mod 2^XLEN)
//   PCSrc, PCTarget   one-cycle redirect pulse and target (bits[1:0] dropped)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget
);

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  // FETCH: request outstanding at r_pc.
  // HOLD : instruction presented to decode, no request.
  // DRAIN: request outstanding but already redirected; its data is dropped.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_run;      // low through the first edge after reset release
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pending;  // redirect target waiting for a drain to finish
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_valid;

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_target   = PCTarget & ALIGN_MASK;
  assign w_pc_plus4 = r_pc + PC_STEP;

  // Request is a pure function of state, so it cannot glitch with inputs and
  // stays stable (with the address) until the memory acknowledges.
  assign imem_req       = r_run && (r_state != S_HOLD);
  assign imem_addr      = r_pc;
  assign instr_valid    = r_valid;
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;
  assign instr_pc_plus4 = r_instr_pc + PC_STEP;
  assign op             = r_instr[6:0];
  assign funct3         = r_instr[14:12];
  assign funct7         = r_instr[31:25];

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FETCH;
      r_run      <= 1'b0;
      r_pc       <= RESET_PC;
      r_pending  <= '0;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= RESET_PC;
      r_valid    <= 1'b0;
    end else begin
      r_run <= 1'b1;
      unique case (r_state)
        S_FETCH: begin
          if (!r_run) begin
            // No request is on the bus yet, so a redirect simply moves the PC.
            if (PCSrc) r_pc <= w_target;
          end else if (imem_ack && !PCSrc) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_valid    <= 1'b1;
            r_pc       <= w_pc_plus4;
            r_state    <= S_HOLD;
          end else if (imem_ack) begin
            // Data returned in the redirect cycle is already stale.
            r_pc <= w_target;
          end else if (PCSrc) begin
            r_pending <= w_target;
            r_state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (PCSrc) r_pending <= w_target;
          if (imem_ack) begin
            // The most recent redirect wins, including one in the ack cycle.
            r_pc    <= PCSrc ? w_target : r_pending;
            r_state <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (PCSrc) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
            r_pc    <= w_target;
            r_state <= S_FETCH;
          end else if (instr_ready) begin
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. Two instances share all inputs:
// dut0 with RESET_PC=0 and dut1 with RESET_PC=FFFF_FFFC (PC wrap). The
// directed part walks a table of fetch vectors and hand-written redirect and
// reset sequences; the random part drives random acks, stalls and redirects
// and checks deliveries against a program-order model of the PC.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_ready;
  logic        PCSrc;
  logic [31:0] PCTarget;

  logic        imem_req,  imem_req_w;
  logic [31:0] imem_addr, imem_addr_w;
  logic        instr_valid, instr_valid_w;
  logic [31:0] instr, instr_w;
  logic [6:0]  op, op_w;
  logic [2:0]  funct3, funct3_w;
  logic [6:0]  funct7, funct7_w;
  logic [31:0] instr_pc, instr_pc_w;
  logic [31:0] instr_pc_plus4, instr_pc_plus4_w;

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .op(op), .funct3(funct3), .funct7(funct7),
    .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4),
    .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid_w), .instr_ready(instr_ready),
    .instr(instr_w), .op(op_w), .funct3(funct3_w), .funct7(funct7_w),
    .instr_pc(instr_pc_w), .instr_pc_plus4(instr_pc_plus4_w),
    .PCSrc(PCSrc), .PCTarget(PCTarget)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Deterministic memory contents for the random phase: word depends on address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Pre-edge snapshot of everything the random checks compare across a cycle.
  logic        p_req, p_ack, p_valid, p_ready, p_pcsrc;
  logic [31:0] p_addr, p_instr, p_ipc;
  always @(posedge clk) begin
    p_req   <= imem_req;
    p_ack   <= imem_ack;
    p_addr  <= imem_addr;
    p_valid <= instr_valid;
    p_instr <= instr;
    p_ipc   <= instr_pc;
    p_ready <= instr_ready;
    p_pcsrc <= PCSrc;
  end

  // Called at a negedge; returns at the first negedge where a request is up.
  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " req timeout"}, imem_req, 1'b1);
  endtask

  // Wait for the request, keep it waiting 'delay' cycles, then ack one cycle.
  task automatic serve(input string name, input int delay, input logic [31:0] data);
    logic [31:0] a;
    wait_req(name);
    a = imem_addr;
    repeat (delay) begin
      @(negedge clk);
      check({name, " req held"}, imem_req, 1'b1);
      check({name, " addr held"}, imem_addr, a);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  typedef struct {
    logic [31:0] rdata;
    int          stall;
    logic [31:0] exp_pc;
    logic [6:0]  exp_op;
    logic [2:0]  exp_f3;
    logic [6:0]  exp_f7;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] hold_instr;
    logic [31:0] exp_pc;
    logic [31:0] w;
    int          n_deliv;

    vecs[0] = '{32'h00A0_0093, 0, 32'h0000_0000, 7'b0010011, 3'b000, 7'b0000000};
    vecs[1] = '{32'h4020_8033, 5, 32'h0000_0004, 7'b0110011, 3'b000, 7'b0100000};
    vecs[2] = '{32'h0020_9463, 0, 32'h0000_0008, 7'b1100011, 3'b001, 7'b0000000};
    vecs[3] = '{32'hFE01_0113, 2, 32'h0000_000C, 7'b0010011, 3'b000, 7'b1111111};

    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    PCSrc       = 1'b0;
    PCTarget    = '0;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk);
    check("rst req",        imem_req,         1'b0);
    check("rst valid",      instr_valid,      1'b0);
    check("rst instr",      instr,            NOP);
    check("rst pc",         instr_pc,         32'h0);
    check("rst pc4",        instr_pc_plus4,   32'h4);
    check("rst addr",       imem_addr,        32'h0);
    check("rst wrap addr",  imem_addr_w,      32'hFFFF_FFFC);
    check("rst wrap pc4",   instr_pc_plus4_w, 32'h0);
    rst_n = 1'b1;

    // ---------------- table-driven sequential fetch + stalls ----------------
    for (int i = 0; i < 4; i++) begin
      wait_req("vec");
      check("vec addr",      imem_addr,   vecs[i].exp_pc);
      check("vec wrap addr", imem_addr_w, vecs[i].exp_pc + 32'hFFFF_FFFC);
      serve("vec", 1, vecs[i].rdata);
      check("vec valid",  instr_valid,    1'b1);
      check("vec instr",  instr,          vecs[i].rdata);
      check("vec pc",     instr_pc,       vecs[i].exp_pc);
      check("vec pc4",    instr_pc_plus4, vecs[i].exp_pc + 32'h4);
      check("vec op",     op,             vecs[i].exp_op);
      check("vec funct3", funct3,         vecs[i].exp_f3);
      check("vec funct7", funct7,         vecs[i].exp_f7);
      check("vec req low in hold", imem_req, 1'b0);
      check("vec wrap pc", instr_pc_w, vecs[i].exp_pc + 32'hFFFF_FFFC);
      for (int s = 0; s < vecs[i].stall; s++) begin
        @(negedge clk);
        check("stall valid", instr_valid, 1'b1);
        check("stall instr", instr,       vecs[i].rdata);
        check("stall pc",    instr_pc,    vecs[i].exp_pc);
        check("stall req",   imem_req,    1'b0);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      instr_ready = 1'b0;
      check("consume valid", instr_valid, 1'b0);
      check("consume req",   imem_req,    1'b1);
      check("consume addr",  imem_addr,   vecs[i].exp_pc + 32'h4);
    end

    // ---------------- redirect in HOLD ----------------
    serve("hold", 1, 32'h0000_0033);
    check("hold pc", instr_pc, 32'h10);
    PCSrc = 1'b1; PCTarget = 32'h0000_0103;
    @(negedge clk);
    PCSrc = 1'b0;
    check("redir hold valid",     instr_valid, 1'b0);
    check("redir hold instr",     instr,       NOP);
    check("redir hold req",       imem_req,    1'b1);
    check("redir hold addr",      imem_addr,   32'h0000_0100);
    check("redir hold wrap addr", imem_addr_w, 32'h0000_0100);

    // ---------------- redirect during outstanding request ----------------
    @(negedge clk);                     // first wait cycle
    PCSrc = 1'b1; PCTarget = 32'h0000_0040;
    @(negedge clk);
    PCSrc = 1'b0;
    check("drain req",  imem_req,  1'b1);
    check("drain addr", imem_addr, 32'h0000_0100);
    @(negedge clk);
    check("drain addr2", imem_addr, 32'h0000_0100);
    imem_ack = 1'b1; imem_rdata = 32'h00A0_0093;
    @(negedge clk);
    imem_ack = 1'b0;
    check("drain stale valid", instr_valid, 1'b0);
    check("drain next addr",   imem_addr,   32'h0000_0040);
    check("drain next req",    imem_req,    1'b1);
    @(negedge clk);
    check("drain stale valid2", instr_valid, 1'b0);

    // second redirect while draining: last one wins
    PCSrc = 1'b1; PCTarget = 32'h0000_0060;
    @(negedge clk);
    PCTarget = 32'h0000_0080;
    check("drain2 addr", imem_addr, 32'h0000_0040);
    @(negedge clk);
    PCSrc = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'h4020_8033;
    @(negedge clk);
    imem_ack = 1'b0;
    check("drain2 valid", instr_valid, 1'b0);
    check("drain2 addr",  imem_addr,   32'h0000_0080);

    // ---------------- redirect coincident with ack ----------------
    imem_ack = 1'b1; imem_rdata = 32'h0020_9463;
    PCSrc = 1'b1; PCTarget = 32'h0000_0200;
    @(negedge clk);
    imem_ack = 1'b0; PCSrc = 1'b0;
    check("coinc valid", instr_valid, 1'b0);
    check("coinc addr",  imem_addr,   32'h0000_0200);
    check("coinc req",   imem_req,    1'b1);
    serve("post", 1, 32'h4020_8033);
    check("post valid", instr_valid, 1'b1);
    check("post pc",    instr_pc,    32'h0000_0200);
    check("post instr", instr,       32'h4020_8033);

    // ---------------- reset mid-HOLD, stray ack during reset ----------------
    #2 rst_n = 1'b0;
    #1;
    check("rhold valid",     instr_valid,    1'b0);
    check("rhold instr",     instr,          NOP);
    check("rhold pc",        instr_pc,       32'h0);
    check("rhold pc4",       instr_pc_plus4, 32'h4);
    check("rhold req",       imem_req,       1'b0);
    check("rhold addr",      imem_addr,      32'h0);
    check("rhold wrap addr", imem_addr_w,    32'hFFFF_FFFC);
    @(negedge clk);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("rhold stray ack", instr_valid, 1'b0);
    rst_n = 1'b1;
    wait_req("rhold");
    check("rhold first addr", imem_addr,   32'h0);
    check("rhold first valid", instr_valid, 1'b0);

    // ---------------- reset mid-DRAIN ----------------
    PCSrc = 1'b1; PCTarget = 32'h0000_0300;
    @(negedge clk);
    PCSrc = 1'b0;
    check("rdrain pre addr", imem_addr, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rdrain req",   imem_req,    1'b0);
    check("rdrain addr",  imem_addr,   32'h0);
    check("rdrain valid", instr_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_req("rdrain");
    check("rdrain first addr", imem_addr, 32'h0);
    serve("rdrain", 1, 32'h0020_9463);
    check("rdrain deliv pc",    instr_pc,    32'h0);
    check("rdrain deliv instr", instr,       32'h0020_9463);
    check("rdrain deliv valid", instr_valid, 1'b1);

    // ---------------- random phase ----------------
    // Model: deliveries must follow program order from the last redirect;
    // each delivered word is the memory word at its own PC.
    exp_pc  = 32'h4;
    n_deliv = 0;
    hold_instr = instr;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (imem_req)
        check("rnd addr align", {30'b0, imem_addr[1:0]}, 32'h0);
      if (instr_valid)
        check("rnd req in hold", imem_req, 1'b0);
      if (p_req && !p_ack) begin
        check("rnd req stable",  imem_req,  1'b1);
        check("rnd addr stable", imem_addr, p_addr);
      end
      if (p_valid && !p_ready && !p_pcsrc) begin
        check("rnd stall valid", instr_valid, 1'b1);
        check("rnd stall instr", instr,       p_instr);
        check("rnd stall pc",    instr_pc,    p_ipc);
      end
      if (p_valid && (p_ready || p_pcsrc))
        check("rnd valid drop", instr_valid, 1'b0);
      if (instr_valid && !p_valid) begin
        n_deliv++;
        w = mem_word(exp_pc);
        check("rnd deliv pc",    instr_pc,       exp_pc);
        check("rnd deliv instr", instr,          w);
        check("rnd deliv pc4",   instr_pc_plus4, exp_pc + 32'h4);
        check("rnd deliv op",    op,             w[6:0]);
        check("rnd deliv f3",    funct3,         w[14:12]);
        check("rnd deliv f7",    funct7,         w[31:25]);
        exp_pc = exp_pc + 32'h4;
      end

      // memory: one-cycle ack pulses after a random wait
      if (imem_ack) begin
        imem_ack = 1'b0;
      end else if (imem_req && ($urandom_range(0, 2) == 0)) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end

      instr_ready = ($urandom_range(0, 2) != 0);
      PCSrc       = ($urandom_range(0, 11) == 0);
      PCTarget    = $urandom;
      if (PCSrc) exp_pc = PCTarget & 32'hFFFF_FFFC;
    end
    imem_ack = 1'b0; PCSrc = 1'b0; instr_ready = 1'b0;
    check("rnd deliveries seen", (n_deliv >= 20) ? 32'd1 : 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
